sequencer_lut_loader: RTL and testbench

//  Upstream configuration stage for sequencer_fsm. Assembles 37-bit LUT entries from 32-bit host

---
 rtl/sequencer_lut_loader_if.sv | 29 ++
 rtl/sequencer_lut_loader.sv | 132 +++++++++++++
 tb/tb_sequencer_lut_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sequencer_lut_loader_if.sv
// Host-register and sequencer-LUT-port bundle for sequencer_lut_loader.
// The master modport drives the host strobes; the slave modport is the loader itself.
interface sequencer_lut_loader_if;
  logic        start_load_i;
  logic        end_load_i;
  logic        host_wr_i;
  logic        host_sel_i;
  logic [31:0] host_wdata_i;
  logic        seq_reset_o;
  logic        config_done_o;
  logic        lut_wen_o;
  logic [36:0] lut_wdata_o;
  logic        busy_o;
  logic        load_done_o;
  logic [8:0]  entry_count_o;
  logic [3:0]  err_o;

  modport master (
    output start_load_i, end_load_i, host_wr_i, host_sel_i, host_wdata_i,
    input  seq_reset_o, config_done_o, lut_wen_o, lut_wdata_o, busy_o,
           load_done_o, entry_count_o, err_o
  );

  modport slave (
    input  start_load_i, end_load_i, host_wr_i, host_sel_i, host_wdata_i,
    output seq_reset_o, config_done_o, lut_wen_o, lut_wdata_o, busy_o,
           load_done_o, entry_count_o, err_o
  );
endinterface

// File: rtl/sequencer_lut_loader.sv
// Assembles 37-bit sequencer LUT entries from LO/HI host writes and owns the
// sequencer reset / config_done handshake around each load session.
module sequencer_lut_loader #(
  parameter int DEPTH         = 256,
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_ni,
  sequencer_lut_loader_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_LOAD, S_FINISH} state_e;

  typedef struct packed {
    logic empty;
    logic seq;
    logic addr;
    logic ovf;
  } err_t;

  state_e      state_q;
  logic [15:0] tmr_q;
  logic        seq_reset_q, cfg_done_q, wen_q, load_done_q, lo_vld_q;
  logic [36:0] wdata_q;
  logic [31:0] lo_q;
  logic [8:0]  cnt_q;
  err_t        err_q;

  logic        in_load, lo_wr, hi_wr, full, commit_d;
  logic [7:0]  next_addr_d;
  logic [36:0] entry_d;

  assign in_load     = (state_q == S_LOAD);
  assign lo_wr       = in_load && bus.host_wr_i && !bus.host_sel_i;
  assign hi_wr       = in_load && bus.host_wr_i &&  bus.host_sel_i;
  assign full        = (cnt_q == 9'(DEPTH));
  assign commit_d    = hi_wr && lo_vld_q && !full;
  assign entry_d     = {bus.host_wdata_i[4:0], lo_q};
  assign next_addr_d = entry_d[36:29];

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      seq_reset_q <= 1'b1;
      cfg_done_q  <= 1'b0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      load_done_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= '0;
      lo_q        <= '0;
      lo_vld_q    <= 1'b0;
    end else begin
      wen_q       <= 1'b0;
      load_done_q <= 1'b0;
      // A new session preempts everything, including a commit arriving this cycle.
      if (bus.start_load_i) begin
        state_q     <= S_ARM;
        tmr_q       <= 16'(RESET_CYCLES - 1);
        seq_reset_q <= 1'b1;
        cfg_done_q  <= 1'b0;
        cnt_q       <= '0;
        err_q       <= '0;
        lo_vld_q    <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: ;
          S_ARM: begin
            if (tmr_q == 16'd0) begin
              state_q     <= S_LOAD;
              seq_reset_q <= 1'b0;
            end else begin
              tmr_q <= tmr_q - 16'd1;
            end
          end
          S_LOAD: begin
            if (lo_wr) begin
              lo_q     <= bus.host_wdata_i;
              lo_vld_q <= 1'b1;
            end
            if (hi_wr) begin
              if (!lo_vld_q) begin
                err_q.seq <= 1'b1;
              end else begin
                lo_vld_q <= 1'b0;
                if (full) begin
                  err_q.ovf <= 1'b1;
                end else begin
                  wen_q   <= 1'b1;
                  wdata_q <= entry_d;
                  cnt_q   <= cnt_q + 9'd1;
                  if ({1'b0, next_addr_d} >= 9'(DEPTH)) err_q.addr <= 1'b1;
                end
              end
            end
            // A commit in the same cycle counts toward the non-empty check.
            if (bus.end_load_i) begin
              if (cnt_q != 9'd0 || commit_d) begin
                state_q <= S_FINISH;
                tmr_q   <= 16'(SETTLE_CYCLES - 1);
              end else begin
                err_q.empty <= 1'b1;
              end
            end
          end
          S_FINISH: begin
            if (tmr_q == 16'd0) begin
              state_q     <= S_IDLE;
              cfg_done_q  <= 1'b1;
              load_done_q <= 1'b1;
            end else begin
              tmr_q <= tmr_q - 16'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.seq_reset_o   = seq_reset_q;
  assign bus.config_done_o = cfg_done_q;
  assign bus.lut_wen_o     = wen_q;
  assign bus.lut_wdata_o   = wdata_q;
  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.load_done_o   = load_done_q;
  assign bus.entry_count_o = cnt_q;
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_sequencer_lut_loader.sv
// Directed bench for sequencer_lut_loader: a per-cycle vector table on a DEPTH=256
// instance plus hand sequences for long loads, restarts, collisions and DEPTH=4 limits.
module tb_sequencer_lut_loader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sequencer_lut_loader_if bus ();
  sequencer_lut_loader_if bus4 ();

  sequencer_lut_loader #(.DEPTH(256), .RESET_CYCLES(4), .SETTLE_CYCLES(2))
    dut (.clk(clk), .reset_ni(rst_n), .bus(bus.slave));
  sequencer_lut_loader #(.DEPTH(4), .RESET_CYCLES(4), .SETTLE_CYCLES(2))
    dut4 (.clk(clk), .reset_ni(rst_n), .bus(bus4.slave));

  typedef struct {
    logic        st, en, wr, sel;
    logic [31:0] wd;
    logic        srst, cfg, wen;
    logic [36:0] wdat;
    logic        busy, ld;
    logic [8:0]  cnt;
    logic [3:0]  err;
  } vec_t;

  vec_t tbl [17];
  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic en, input logic wr, input logic sel,
                       input logic [31:0] wd);
    bus.start_load_i  = st;  bus4.start_load_i  = st;
    bus.end_load_i    = en;  bus4.end_load_i    = en;
    bus.host_wr_i     = wr;  bus4.host_wr_i     = wr;
    bus.host_sel_i    = sel; bus4.host_sel_i    = sel;
    bus.host_wdata_i  = wd;  bus4.host_wdata_i  = wd;
  endtask

  // Apply inputs for one cycle; return just after the edge with inputs idle.
  task automatic cyc(input logic st, input logic en, input logic wr, input logic sel,
                     input logic [31:0] wd);
    drive(st, en, wr, sel, wd);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  function automatic logic [36:0] mk_entry(input int i);
    logic [2:0] ns;
    ns = (i == 0) ? 3'd2 : 3'(i % 8);
    return {8'(i + 1), 1'b0, 1'b0, 16'(5 + i), 8'(i), ns};
  endfunction

  initial begin
    int npulse, cfg_k, nld, nhigh;
    logic [36:0] e;

    tbl[0]  = '{0,0,0,0,32'h0,          1,0,0,37'h0,           0,0,9'd0,4'b0000};
    tbl[1]  = '{1,0,0,0,32'h0,          1,0,0,37'h0,           1,0,9'd0,4'b0000};
    tbl[2]  = '{0,0,1,0,32'h1234_5678,  1,0,0,37'h0,           1,0,9'd0,4'b0000};
    tbl[3]  = '{0,0,0,0,32'h0,          1,0,0,37'h0,           1,0,9'd0,4'b0000};
    tbl[4]  = '{0,0,0,0,32'h0,          1,0,0,37'h0,           1,0,9'd0,4'b0000};
    tbl[5]  = '{0,0,0,0,32'h0,          0,0,0,37'h0,           1,0,9'd0,4'b0000};
    tbl[6]  = '{0,0,1,1,32'h0,          0,0,0,37'h0,           1,0,9'd0,4'b0100};
    tbl[7]  = '{0,0,1,0,32'h2000_2802,  0,0,0,37'h0,           1,0,9'd0,4'b0100};
    tbl[8]  = '{0,0,1,1,32'h0,          0,0,1,37'h0_2000_2802, 1,0,9'd1,4'b0100};
    tbl[9]  = '{0,0,0,0,32'h0,          0,0,0,37'h0_2000_2802, 1,0,9'd1,4'b0100};
    tbl[10] = '{0,0,1,0,32'hFFFF_FFFF,  0,0,0,37'h0_2000_2802, 1,0,9'd1,4'b0100};
    tbl[11] = '{0,0,1,1,32'h0000_001F,  0,0,1,37'h1F_FFFF_FFFF,1,0,9'd2,4'b0100};
    tbl[12] = '{0,1,0,0,32'h0,          0,0,0,37'h1F_FFFF_FFFF,1,0,9'd2,4'b0100};
    tbl[13] = '{0,0,0,0,32'h0,          0,0,0,37'h1F_FFFF_FFFF,1,0,9'd2,4'b0100};
    tbl[14] = '{0,0,0,0,32'h0,          0,1,0,37'h1F_FFFF_FFFF,0,1,9'd2,4'b0100};
    tbl[15] = '{0,0,0,0,32'h0,          0,1,0,37'h1F_FFFF_FFFF,0,0,9'd2,4'b0100};
    tbl[16] = '{1,0,0,0,32'h0,          1,0,0,37'h1F_FFFF_FFFF,1,0,9'd0,4'b0000};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    chk("rst_seq_reset", bus.seq_reset_o, 1);
    chk("rst_cfg_done",  bus.config_done_o, 0);
    chk("rst_wen",       bus.lut_wen_o, 0);
    chk("rst_wdata",     bus.lut_wdata_o, 0);
    chk("rst_err",       bus.err_o, 0);
    chk("rst_busy",      bus.busy_o, 0);
    chk("rst_count",     bus.entry_count_o, 0);
    chk("rst4_seq_reset", bus4.seq_reset_o, 1);
    rst_n = 1'b1;

    // Per-cycle vector table: ARM timing, HI-without-LO, commits, FINISH, restart
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].st, tbl[i].en, tbl[i].wr, tbl[i].sel, tbl[i].wd);
      chk($sformatf("v%0d_seq_reset", i), bus.seq_reset_o,   tbl[i].srst);
      chk($sformatf("v%0d_cfg_done", i),  bus.config_done_o, tbl[i].cfg);
      chk($sformatf("v%0d_wen", i),       bus.lut_wen_o,     tbl[i].wen);
      chk($sformatf("v%0d_wdata", i),     bus.lut_wdata_o,   tbl[i].wdat);
      chk($sformatf("v%0d_busy", i),      bus.busy_o,        tbl[i].busy);
      chk($sformatf("v%0d_load_done", i), bus.load_done_o,   tbl[i].ld);
      chk($sformatf("v%0d_count", i),     bus.entry_count_o, tbl[i].cnt);
      chk($sformatf("v%0d_err", i),       bus.err_o,         tbl[i].err);
    end

    // 15-entry load, one entry per two cycles
    idle(4);
    chk("load15_armed", bus.seq_reset_o, 0);
    npulse = 0;
    for (int i = 0; i < 15; i++) begin
      e = mk_entry(i);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, e[31:0]);
      if (bus.lut_wen_o) npulse++;
      cyc(1'b0, 1'b0, 1'b1, 1'b1, {27'h0, e[36:32]});
      if (bus.lut_wen_o) npulse++;
      chk($sformatf("load15_e%0d", i), bus.lut_wdata_o, e);
      if (i == 0) chk("load15_entry0", bus.lut_wdata_o, 37'h0_2000_2802);
    end
    chk("load15_pulses", npulse, 15);
    chk("load15_count", bus.entry_count_o, 15);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("load15_finish_busy", bus.busy_o, 1);
    cfg_k = -1;
    nld = 0;
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      if (bus.load_done_o) nld++;
      if (bus.config_done_o && cfg_k < 0) cfg_k = k;
    end
    chk("load15_cfg_latency", cfg_k, 2);
    chk("load15_load_done_once", nld, 1);
    chk("load15_err", bus.err_o, 0);
    chk("load15_idle", bus.busy_o, 0);
    chk("load15_cfg_held", bus.config_done_o, 1);

    // end_load with no entries stays in LOAD
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("empty_err", bus.err_o, 4'b1000);
    chk("empty_busy", bus.busy_o, 1);
    idle(3);
    chk("empty_no_cfg", bus.config_done_o, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0001);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    chk("empty_still_load_wen", bus.lut_wen_o, 1);

    // Restart mid-LOAD after 3 entries, with a coincident HI write suppressed
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0001);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    end
    chk("restart_pre_count", bus.entry_count_o, 3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0001);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    chk("restart_wen_suppressed", bus.lut_wen_o, 0);
    chk("restart_count", bus.entry_count_o, 0);
    chk("restart_err", bus.err_o, 0);
    nhigh = bus.seq_reset_o ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      idle(1);
      if (bus.seq_reset_o) nhigh++;
    end
    chk("restart_reset_cycles", nhigh, 4);

    // HI write coincident with end_load: pulse lands in the first FINISH cycle
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h2000_2802);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    chk("coll_wen", bus.lut_wen_o, 1);
    chk("coll_wdata", bus.lut_wdata_o, 37'h0_2000_2802);
    chk("coll_count", bus.entry_count_o, 1);
    chk("coll_busy", bus.busy_o, 1);
    idle(1);
    chk("coll_wen_off", bus.lut_wen_o, 0);
    chk("coll_cfg_early", bus.config_done_o, 0);
    idle(1);
    chk("coll_cfg", bus.config_done_o, 1);
    chk("coll_load_done", bus.load_done_o, 1);

    // DEPTH=4 limits: 5 pairs, second entry has next_addr 4
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(4);
    npulse = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, (i == 1) ? 32'h8000_0000 : 32'h0000_0001);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      if (bus4.lut_wen_o) npulse++;
      if (i == 1) chk("lim_addr_entry", bus4.lut_wdata_o, 37'h0_8000_0000);
    end
    chk("lim_pulses", npulse, 4);
    chk("lim_count", bus4.entry_count_o, 4);
    chk("lim_err", bus4.err_o, 4'b0011);

    // Asynchronous reset mid-session
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_seq_reset", bus4.seq_reset_o, 1);
    chk("arst_busy", bus4.busy_o, 0);
    chk("arst_count", bus4.entry_count_o, 0);
    chk("arst_err", bus4.err_o, 0);
    chk("arst_busy_main", bus.busy_o, 0);
    #3;
    rst_n = 1'b1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
